// File: rtl/mem_access_unit_if.sv
// Memory-side request/response bus between the M-stage access unit and the data memory.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: aligns stores onto byte lanes, issues one memory request
// per access, stalls the pipeline until completion, and extends load data.
module mem_access_unit #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MemWriteM,
  input  logic [1:0]                ResultSrcM,
  input  logic [31:0]               ALUResultM,
  input  logic [31:0]               WriteDataM,
  input  logic [2:0]                funct3M,
  mem_access_unit_if.master         mem,
  output logic [31:0]               ReadDataM,
  output logic                      StallM,
  output logic                      ErrM
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        err_q;
  logic [2:0]  req_f3;
  logic [1:0]  req_off;
  logic        req_load;

  logic        is_load, access, legal, misalign, fault;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, lane, load_ext;

  always_comb begin
    is_load  = !MemWriteM && (ResultSrcM == 2'b01);
    access   = MemWriteM || is_load;
    legal    = MemWriteM ? (funct3M inside {3'b000, 3'b001, 3'b010})
                         : (funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign = 1'b0;
    be_c     = 4'b1111;
    wdata_c  = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ALUResultM[1:0];
        wdata_c = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        misalign = ALUResultM[0];
        be_c     = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{WriteDataM[15:0]}};
      end
      2'b10: misalign = |ALUResultM[1:0];
      default: ;
    endcase
    fault = access && (!legal || misalign);
  end

  // Shifting the addressed lane down to bit 0 lets every size share one extender.
  always_comb begin
    lane = mem.mem_rdata >> {req_off, 3'b000};
    case (req_f3)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  assign StallM = !reset && access && !fault && (state != DONE);
  assign ErrM   = !reset && (((state == IDLE) && access && fault) || err_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_be    <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      ReadDataM     <= '0;
      cnt           <= '0;
      err_q         <= 1'b0;
      req_f3        <= '0;
      req_off       <= '0;
      req_load      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (access && !fault) begin
            state         <= BUSY;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= MemWriteM;
            mem.mem_addr  <= {ALUResultM[31:2], 2'b00};
            mem.mem_wdata <= wdata_c;
            mem.mem_be    <= be_c;
            cnt           <= '0;
            req_f3        <= funct3M;
            req_off       <= ALUResultM[1:0];
            req_load      <= is_load;
          end
        end
        BUSY: begin
          if (mem.mem_ready) begin
            mem.mem_req <= 1'b0;
            state       <= DONE;
            if (req_load) ReadDataM <= load_ext;
          end else if (cnt == TIMEOUT - 8'd1) begin
            // Abort after TIMEOUT unanswered request cycles; ErrM pulses during DONE.
            mem.mem_req <= 1'b0;
            err_q       <= 1'b1;
            ReadDataM   <= '0;
            state       <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT, 8'd255, max cycles waiting for mem_ready before abort.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: MemWriteM  input  1  store in M stage; ResultSrcM  input  2  2'b01 = load in M stage.
REQ-005 SHALL have ports: ALUResultM  input  32  byte address; WriteDataM  input  32  store data; funct3M  input  3  access size/sign.
REQ-006 SHALL have ports: mem_req  output  1  request valid; mem_we  output  1  1 = write; mem_addr  output  32  word-aligned address; mem_wdata  output  32  lane-aligned data; mem_be  output  4  byte enables.
REQ-007 SHALL have ports: mem_ready  input  1  request accepted/completed; mem_rdata  input  32  read word, valid with mem_ready.
REQ-008 SHALL have ports: ReadDataM  output  32  extended load result; StallM  output  1  hold F/D/E/M; ErrM  output  1  access fault.

Function
REQ-009 SHALL define access = MemWriteM | (ResultSrcM==2'b01); MemWriteM takes priority if both set.
REQ-010 SHALL accept funct3M: store 000/001/010 (SB/SH/SW); load 000/001/010/100/101 (LB/LH/LW/LBU/LHU); any other value is a fault.
REQ-011 SHALL treat half at addr[0]=1 or word at addr[1:0]!=0 as a fault.
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL in IDLE, with access and no fault: latch request registers, go BUSY; mem_req=1 from the next cycle.
REQ-014 SHALL in IDLE, with access and fault: issue no request, assert ErrM combinationally, keep StallM=0, stay IDLE.
REQ-015 SHALL in BUSY hold mem_req=1 and mem_we/mem_addr/mem_wdata/mem_be stable until mem_ready sampled 1.
REQ-016 SHALL on mem_ready=1 in BUSY: capture extended mem_rdata into ReadDataM (loads only), deassert mem_req next cycle, go DONE.
REQ-017 SHALL in DONE hold StallM=0 for exactly one cycle, then return to IDLE without re-issuing the access.
REQ-018 SHALL drive StallM = access & no fault & state!=DONE (combinational); minimum access = 2 stall cycles, then 1 release cycle.
REQ-019 SHALL drive mem_addr = {ALUResultM[31:2],2'b00}.
REQ-020 SHALL drive mem_be: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
REQ-021 SHALL drive mem_wdata: byte replicated x4; half replicated x2; word as-is.
REQ-022 SHALL select the load lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass through.
REQ-023 SHALL count BUSY cycles; at TIMEOUT with no mem_ready: drop mem_req, pulse ErrM 1 cycle, ReadDataM=0, go DONE.
REQ-024 SHALL ignore mem_ready in IDLE and DONE.
REQ-025 SHALL leave ReadDataM unchanged by stores and faults.

Reset
REQ-026 SHALL on reset: state=IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, ReadDataM=0, timeout counter=0.
REQ-027 SHALL on reset asserted in BUSY abandon the access; mem_req=0 next cycle; a late mem_ready SHALL have no effect.
REQ-028 SHALL hold StallM and ErrM at 0 while reset is asserted.

Verification
REQ-029 SHALL cover: SW addr 0x100 data 0xDEADBEEF, ready on 1st BUSY cycle -> mem_be=1111, mem_wdata=0xDEADBEEF, StallM high 2 cycles then low 1.
REQ-030 SHALL cover: LB addr 0x103, mem_rdata=0x80FF_FF7F -> mem_be=1000, ReadDataM=0xFFFFFF80; LBU same -> 0x00000080.
REQ-031 SHALL cover: SH addr 0x102 data 0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD.
REQ-032 SHALL cover: LW addr 0x101 -> mem_req stays 0, ErrM=1, StallM=0.
REQ-033 SHALL cover: LH with mem_ready delayed 5 cycles -> mem_req/addr/be stable 5 cycles, StallM high 6 cycles; no ready for TIMEOUT -> ErrM pulse, return to IDLE.
REQ-034 SHALL cover: reset in BUSY then mem_ready next cycle -> IDLE, mem_req=0, ReadDataM=0.
